// File: rtl/z80_bus_ctrl.sv
// Z80 bus-pin slave: turns strobes into one req/ack transaction per CPU cycle; WAIT_L held from
// detection until ack, so there are always >=2 wait clocks; INTA answered directly. BUS_TIMEOUT_EN adds a sticky ack timeout.
module z80_bus_ctrl #(
  parameter logic [7:0] IM_VECTOR      = 8'hFF,
  parameter int         TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] addr_bus,
  input  logic [7:0]  data_in,
  output logic [7:0]  data_out,
  output logic        data_oe,
  input  logic        MREQ_L,
  input  logic        IORQ_L,
  input  logic        RD_L,
  input  logic        WR_L,
  input  logic        M1_L,
  input  logic        RFSH_L,
  output logic        WAIT_L,
  output logic        mem_req,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata,
  input  logic        mem_ack,
  output logic        io_req,
  output logic        io_we,
  output logic [7:0]  io_port,
  output logic [7:0]  io_wdata,
  input  logic [7:0]  io_rdata,
  input  logic        io_ack,
  output logic        bus_err
);

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, DONE = 2'd2} state_t;

  state_t      state_q;
  logic        is_mem_q, is_rd_q, inta_q;
  logic        mem_req_q, mem_we_q, io_req_q, io_we_q;
  logic [15:0] mem_addr_q;
  logic [7:0]  mem_wdata_q, io_port_q, io_wdata_q, data_out_q;

  logic start_w, inta_w, strobes_off_w, ack_w, done_exit_w;

  assign start_w       = (~MREQ_L | ~IORQ_L) & (~RD_L | ~WR_L) & RFSH_L;
  assign inta_w        = ~M1_L & ~IORQ_L;
  assign strobes_off_w = (RD_L & WR_L) | (MREQ_L & IORQ_L);
  assign ack_w         = is_mem_q ? mem_ack : io_ack;
  // INTA carries no RD_L/WR_L, so it is held only by IORQ_L/M1_L
  assign done_exit_w   = inta_q ? (IORQ_L | M1_L) : strobes_off_w;

`ifdef BUS_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_q;
  logic          bus_err_q;
  assign bus_err = bus_err_q;
`else
  localparam int unused_tmo = TIMEOUT_CYCLES;
  assign bus_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      is_mem_q    <= 1'b0;
      is_rd_q     <= 1'b0;
      inta_q      <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      io_req_q    <= 1'b0;
      io_we_q     <= 1'b0;
      mem_addr_q  <= 16'h0000;
      mem_wdata_q <= 8'h00;
      io_port_q   <= 8'h00;
      io_wdata_q  <= 8'h00;
      data_out_q  <= 8'h00;
`ifdef BUS_TIMEOUT_EN
      tmo_q       <= '0;
      bus_err_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (inta_w) begin
            inta_q     <= 1'b1;
            is_rd_q    <= 1'b1;
            data_out_q <= IM_VECTOR;
            state_q    <= DONE;
          end else if (start_w) begin
            inta_q   <= 1'b0;
            is_rd_q  <= ~RD_L;
            is_mem_q <= ~MREQ_L;
            if (~MREQ_L) begin
              mem_req_q   <= 1'b1;
              mem_we_q    <= RD_L;
              mem_addr_q  <= addr_bus;
              mem_wdata_q <= data_in;
            end else begin
              io_req_q   <= 1'b1;
              io_we_q    <= RD_L;
              io_port_q  <= addr_bus[7:0];
              io_wdata_q <= data_in;
            end
`ifdef BUS_TIMEOUT_EN
            tmo_q <= '0;
`endif
            state_q <= REQ;
          end
        end
        REQ: begin
          if (ack_w) begin
            mem_req_q <= 1'b0;
            io_req_q  <= 1'b0;
            if (is_rd_q) data_out_q <= is_mem_q ? mem_rdata : io_rdata;
            state_q   <= DONE;
          end else if (strobes_off_w) begin
            mem_req_q <= 1'b0;
            io_req_q  <= 1'b0;
            state_q   <= IDLE;
          end
`ifdef BUS_TIMEOUT_EN
          else if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
            mem_req_q  <= 1'b0;
            io_req_q   <= 1'b0;
            bus_err_q  <= 1'b1;
            data_out_q <= 8'hFF;
            state_q    <= DONE;
          end else begin
            tmo_q <= tmo_q + TW'(1);
          end
`endif
        end
        DONE: begin
          if (done_exit_w) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Detection-cycle wait is combinational so the CPU samples it in the same T-state
  assign WAIT_L    = ~(~rst & ((state_q == REQ) | ((state_q == IDLE) & start_w & ~inta_w)));
  assign data_oe   = ~rst & (state_q == DONE) & is_rd_q & (inta_q ? ~IORQ_L : ~RD_L);
  assign data_out  = data_out_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign io_req    = io_req_q;
  assign io_we     = io_we_q;
  assign io_port   = io_port_q;
  assign io_wdata  = io_wdata_q;

endmodule

// File: tb/tb_z80_bus_ctrl.sv
// Bench for z80_bus_ctrl: directed test-plan cycles plus randomized transactions against a transaction-level model.
module tb_z80_bus_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] addr_bus;
  logic [7:0]  data_in, data_out, mem_rdata, io_rdata, mem_wdata, io_port, io_wdata;
  logic        data_oe, MREQ_L, IORQ_L, RD_L, WR_L, M1_L, RFSH_L, WAIT_L;
  logic        mem_req, mem_we, mem_ack, io_req, io_we, io_ack, bus_err;
  logic [15:0] mem_addr;

  int total = 0;
  int bad   = 0;
  int mon_wait = 0, mon_mem = 0, mon_io = 0;
  logic [7:0] exp_dout;

  always #5 clk = ~clk;

  z80_bus_ctrl dut (
    .clk(clk), .rst(rst), .addr_bus(addr_bus), .data_in(data_in),
    .data_out(data_out), .data_oe(data_oe),
    .MREQ_L(MREQ_L), .IORQ_L(IORQ_L), .RD_L(RD_L), .WR_L(WR_L), .M1_L(M1_L), .RFSH_L(RFSH_L),
    .WAIT_L(WAIT_L),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .io_req(io_req), .io_we(io_we), .io_port(io_port), .io_wdata(io_wdata),
    .io_rdata(io_rdata), .io_ack(io_ack), .bus_err(bus_err)
  );

  always @(negedge clk) begin
    if (WAIT_L == 1'b0) mon_wait++;
    if (mem_req) mon_mem++;
    if (io_req) mon_io++;
  end

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic bus_idle();
    MREQ_L = 1'b1; IORQ_L = 1'b1; RD_L = 1'b1; WR_L = 1'b1; M1_L = 1'b1; RFSH_L = 1'b1;
    mem_ack = 1'b0; io_ack = 1'b0;
  endtask

  // kind: 0 mem rd, 1 mem wr, 2 io rd, 3 io wr, 4 inta, 5 refresh,
  //       6 MREQ+IORQ read (mem), 7 RD+WR both low (mem read), 8 opcode fetch
  task automatic do_txn(input int kind, input logic [15:0] a, input logic [7:0] wd,
                        input logic [7:0] rv, input int dly, input bit abort);
    bit be, mem, rd;
    int w0, m0, i0;
    rd  = kind inside {0, 2, 6, 7, 8};
    mem = kind inside {0, 1, 6, 7, 8};
    be  = kind inside {0, 1, 2, 3, 6, 7, 8};
    @(posedge clk); #1;
    w0 = mon_wait; m0 = mon_mem; i0 = mon_io;
    addr_bus = a; data_in = wd;
    case (kind)
      0: begin MREQ_L = 0; RD_L = 0; end
      1: begin MREQ_L = 0; WR_L = 0; end
      2: begin IORQ_L = 0; RD_L = 0; end
      3: begin IORQ_L = 0; WR_L = 0; end
      4: begin M1_L = 0; IORQ_L = 0; end
      5: begin MREQ_L = 0; RFSH_L = 0; RD_L = 1'($urandom_range(0, 1)); end
      6: begin MREQ_L = 0; IORQ_L = 0; RD_L = 0; end
      7: begin MREQ_L = 0; RD_L = 0; WR_L = 0; end
      default: begin M1_L = 0; MREQ_L = 0; RD_L = 0; end
    endcase
    if (be) begin
      for (int c = 0; c <= dly; c++) begin
        @(posedge clk); #1;
        mem_ack = 1'b0; io_ack = 1'b0;
        if (c == dly) begin
          if (abort) bus_idle();
          else if (mem) begin mem_ack = 1'b1; mem_rdata = rv; end
          else begin io_ack = 1'b1; io_rdata = rv; end
        end else if ($urandom_range(0, 1) == 1) begin
          if (mem) begin io_ack = 1'b1; io_rdata = ~rv; end
          else begin mem_ack = 1'b1; mem_rdata = ~rv; end
        end
        @(negedge clk);
        if (c == 0) begin
          if (mem) begin
            check("cap_mem_req", mem_req, 1);  check("cap_io_req", io_req, 0);
            check("cap_mem_addr", mem_addr, a); check("cap_mem_we", mem_we, !rd);
            check("cap_mem_wdata", mem_wdata, wd);
          end else begin
            check("cap_io_req", io_req, 1);    check("cap_mem_req", mem_req, 0);
            check("cap_io_port", io_port, a[7:0]); check("cap_io_we", io_we, !rd);
            check("cap_io_wdata", io_wdata, wd);
          end
        end
      end
      @(posedge clk); #1;
      mem_ack = 1'b0; io_ack = 1'b0;
      if (abort) begin
        @(negedge clk);
        check("abort_req", mem_req | io_req, 0);
        check("abort_wait", WAIT_L, 1);
        @(posedge clk); #1;
        if (mem) begin mem_ack = 1'b1; mem_rdata = ~exp_dout; end
        else begin io_ack = 1'b1; io_rdata = ~exp_dout; end
        @(posedge clk); #1;
        mem_ack = 1'b0; io_ack = 1'b0;
        @(negedge clk);
        check("late_ack_dout", data_out, exp_dout);
        check("late_ack_req", mem_req | io_req, 0);
      end else begin
        if (rd) exp_dout = rv;
        @(negedge clk);
        check("done_wait", WAIT_L, 1);
        check("done_req", mem_req | io_req, 0);
        check("done_dout", data_out, exp_dout);
        check("done_oe", data_oe, rd);
        @(posedge clk); #1;
        @(negedge clk);
        check("hold_oe", data_oe, rd);
        @(posedge clk); #1;
        bus_idle();
        @(negedge clk);
        check("rel_oe", data_oe, 0);
        @(posedge clk);
      end
      #1;
      check("wait_cnt", 16'(mon_wait - w0), 16'(dly + 2));
      check("mem_req_cnt", 16'(mon_mem - m0), mem ? 16'(dly + 1) : 16'd0);
      check("io_req_cnt", 16'(mon_io - i0), mem ? 16'd0 : 16'(dly + 1));
    end else if (kind == 4) begin
      @(posedge clk); #1;
      exp_dout = 8'hFF;
      @(negedge clk);
      check("inta_dout", data_out, exp_dout);
      check("inta_oe", data_oe, 1);
      @(posedge clk); #1;
      bus_idle();
      @(negedge clk);
      check("inta_rel_oe", data_oe, 0);
      @(posedge clk); #1;
      check("inta_wait_cnt", 16'(mon_wait - w0), 0);
      check("inta_req_cnt", 16'(mon_mem - m0 + mon_io - i0), 0);
    end else begin
      repeat (3) @(posedge clk);
      #1;
      bus_idle();
      @(posedge clk); #1;
      check("rfsh_wait_cnt", 16'(mon_wait - w0), 0);
      check("rfsh_req_cnt", 16'(mon_mem - m0 + mon_io - i0), 0);
      check("rfsh_dout", data_out, exp_dout);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    bus_idle();
    addr_bus = 16'h0; data_in = 8'h0; mem_rdata = 8'h0; io_rdata = 8'h0;
    exp_dout = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    check("rst_wait", WAIT_L, 1);       check("rst_oe", data_oe, 0);
    check("rst_dout", data_out, 0);     check("rst_mem_req", mem_req, 0);
    check("rst_io_req", io_req, 0);     check("rst_mem_we", mem_we, 0);
    check("rst_io_we", io_we, 0);       check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0); check("rst_io_wdata", io_wdata, 0);
    check("rst_io_port", io_port, 0);   check("rst_bus_err", bus_err, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    do_txn(0, 16'h1234, 8'h00, 8'hA5, 0, 0);
    do_txn(1, 16'h8000, 8'h3C, 8'h00, 4, 0);
    do_txn(2, 16'h00FE, 8'h00, 8'h5A, 1, 0);
    do_txn(4, 16'h0000, 8'h00, 8'h00, 0, 0);
    do_txn(5, 16'h0042, 8'h00, 8'h00, 0, 0);
    do_txn(0, 16'h2222, 8'h00, 8'h77, 2, 1);

    for (int n = 0; n < 40; n++) begin
      int  k;
      k = $urandom_range(0, 8);
      do_txn(k, 16'($urandom), 8'($urandom), 8'($urandom), $urandom_range(0, 6),
             (k != 4 && k != 5) && ($urandom_range(0, 5) == 0));
    end

    @(posedge clk); #1;
    addr_bus = 16'h4321; MREQ_L = 1'b0; RD_L = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check("pre_rst_req", mem_req, 1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    exp_dout = 8'h00;
    @(negedge clk);
    check("mid_rst_wait", WAIT_L, 1);
    check("mid_rst_req", mem_req, 0);
    check("mid_rst_addr", mem_addr, 0);
    check("mid_rst_dout", data_out, exp_dout);
    bus_idle();
    rst = 1'b0;

`ifdef BUS_TIMEOUT_EN
    @(posedge clk); #1;
    begin
      int w0, m0;
      w0 = mon_wait; m0 = mon_mem;
      addr_bus = 16'hBEEF; MREQ_L = 1'b0; RD_L = 1'b0;
      repeat (64) @(posedge clk);
      @(negedge clk);
      check("tmo_req_hold", mem_req, 1);
      check("tmo_err_early", bus_err, 0);
      @(posedge clk); #1;
      exp_dout = 8'hFF;
      @(negedge clk);
      check("tmo_req", mem_req, 0);
      check("tmo_err", bus_err, 1);
      check("tmo_dout", data_out, exp_dout);
      check("tmo_oe", data_oe, 1);
      check("tmo_wait_cnt", 16'(mon_wait - w0), 65);
      check("tmo_req_cnt", 16'(mon_mem - m0), 64);
      @(posedge clk); #1;
      bus_idle();
      @(posedge clk);
    end
    do_txn(2, 16'h0011, 8'h00, 8'h99, 1, 0);
    check("tmo_err_sticky", bus_err, 1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_dout = 8'h00;
    check("tmo_err_clr", bus_err, 0);
`else
    do_txn(3, 16'h0033, 8'hC3, 8'h00, 6, 0);
    check("no_tmo_err", bus_err, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/z80_bus_ctrl.md
Name: z80_bus_ctrl

Overview:
- Bus-side slave controller sitting directly downstream of the z80 core's external bus pins.
- Decodes MREQ_L/IORQ_L/RD_L/WR_L/M1_L/RFSH_L into single req/ack transactions toward a memory backend and an I/O backend.
- Stretches the CPU cycle with WAIT_L until the backend acknowledges, and returns read data on the CPU data bus.
- Also answers interrupt-acknowledge cycles with a fixed vector.

Parameters:
- IM_VECTOR, 8'hFF: byte driven during interrupt-acknowledge (M1_L & IORQ_L both low).
- TIMEOUT_CYCLES, 64: backend ack timeout in clocks; only used with BUS_TIMEOUT_EN.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  synchronous reset, active-high.
- addr_bus  in  16  CPU address.
- data_in  in  8  CPU write data (CPU data_bus value).
- data_out  out  8  read data toward CPU.
- data_oe  out  1  high when data_out must be driven onto the CPU data bus.
- MREQ_L, IORQ_L, RD_L, WR_L, M1_L, RFSH_L  in  1 each  CPU bus strobes, active-low.
- WAIT_L  out  1  active-low wait request to the CPU.
- mem_req  out  1  memory request, level.
- mem_we  out  1  1 = write.
- mem_addr  out  16  memory address.
- mem_wdata  out  8  memory write data.
- mem_rdata  in  8  memory read data; valid with mem_ack.
- mem_ack  in  1  one-cycle completion pulse.
- io_req, io_we  out  1 each  I/O request and write flag.
- io_port  out  8  addr_bus[7:0].
- io_wdata  out  8  I/O write data.
- io_rdata  in  8  I/O read data.
- io_ack  in  1  one-cycle completion pulse.
- bus_err  out  1  sticky timeout flag; constant 0 without BUS_TIMEOUT_EN.

Behaviour:
- Reset values:
  - state IDLE; WAIT_L=1, data_oe=0, data_out=8'h00.
  - mem_req=io_req=0, mem_we=io_we=0, mem_addr=16'h0000, mem_wdata=io_wdata=8'h00, io_port=8'h00, bus_err=0.
- Cycle-start decode, evaluated in IDLE only:
  - start = (~MREQ_L | ~IORQ_L) & (~RD_L | ~WR_L) & RFSH_L.
  - MREQ_L low with RFSH_L low (refresh) is ignored.
  - If MREQ_L and IORQ_L are both low and M1_L is high, the cycle is treated as memory.
  - If RD_L and WR_L are both low, the cycle is treated as a read.
- Interrupt acknowledge:
  - ~M1_L & ~IORQ_L in IDLE → go to DONE directly, with data_out=IM_VECTOR and no backend request.
  - WAIT_L is never pulled low for this cycle.
- FSM states: IDLE, REQ, DONE.
- IDLE → REQ on start (non-INTA):
  - Capture addr_bus, data_in and the write flag into the mem_* or io_* outputs.
  - Assert mem_req or io_req from the next cycle.
  - WAIT_L is combinationally 0 in the detection cycle; this guarantees at least one wait state.
- REQ:
  - req held high and WAIT_L=0 until the matching ack.
  - On ack: drop req the same edge, latch rdata into data_out for reads, go to DONE.
  - An ack from the non-selected backend is ignored.
- DONE:
  - WAIT_L=1.
  - data_oe = read cycle & ~RD_L (combinational on RD_L).
  - Leave to IDLE when (RD_L & WR_L) or (MREQ_L & IORQ_L); the same cycle's strobes are never re-served.
- Latency: a backend that acks in the first REQ cycle gives WAIT_L low for exactly 2 clocks.
- Acks arriving in IDLE or DONE are ignored.
- CPU strobes released while in REQ (abort): drop req next edge, return to IDLE, WAIT_L=1; a later ack is ignored.
- rst asserted mid-transaction: everything returns to reset values the next edge.

Optional Feature:
- Macro: BUS_TIMEOUT_EN.
- When defined:
  - A counter runs in REQ.
  - If no ack arrives within TIMEOUT_CYCLES clocks: drop req, set bus_err (sticky until rst), complete with data_out=8'hFF, go to DONE.
- When undefined: no counter; REQ waits indefinitely; bus_err tied 0.

Test Plan:
- Memory read: MREQ_L=RD_L=0, addr 16'h1234; mem_ack one cycle after mem_req with mem_rdata=8'hA5 → mem_addr=16'h1234, mem_we=0, WAIT_L low 2 clocks, then data_out=8'hA5 with data_oe=1 until RD_L rises.
- Memory write: MREQ_L=WR_L=0, addr 16'h8000, data_in=8'h3C; ack after 5 cycles → mem_we=1, mem_wdata=8'h3C, WAIT_L low 6 clocks, data_oe stays 0.
- I/O read: IORQ_L=RD_L=0, addr 16'h00FE; io_ack with io_rdata=8'h5A → io_port=8'hFE, mem_req never asserted, data_out=8'h5A.
- INTA and refresh:
  - M1_L=IORQ_L=0 → data_out=8'hFF, data_oe=1, WAIT_L never low.
  - MREQ_L=RFSH_L=0 → no request issued.
- Abort and reset:
  - Strobes released in REQ → req drops next clock; a later mem_ack is ignored.
  - rst in REQ → WAIT_L=1, mem_req=0 next edge.
- With BUS_TIMEOUT_EN: never ack → after 64 clocks req drops, bus_err=1, data_out=8'hFF; bus_err cleared only by rst.
